// File: rtl/rob_mc.sv
// rob_mc: multi-retire reorder buffer with an internal tag-to-slot map for recovery.
// Define ROB_STATS_EN to add saturating retire/recover/full/bad-recover counters.

module rob_mc_lane #(
  parameter int PREG_W = 7
) (
  input  logic              i_commit,
  input  logic              i_rd_used,
  input  logic [PREG_W-1:0] i_old_prd,
  output logic              o_free_req,
  output logic [PREG_W-1:0] o_free_preg
);
  // preg 0 is never returned to the free list
  assign o_free_req  = i_commit && i_rd_used && (i_old_prd != '0);
  assign o_free_preg = o_free_req ? i_old_prd : '0;
endmodule

module rob_mc #(
  parameter int  DEPTH    = 16,
  parameter int  COMMIT_W = 2,
  parameter int  WB_PORTS = 3,
  parameter int  ROB_W    = $clog2(DEPTH),
  parameter int  PREG_W   = 7,
  localparam int CNT_W    = $clog2(COMMIT_W+1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush_i,
  input  logic                       recover_i,
  input  logic [ROB_W-1:0]           recover_tag_i,
  input  logic                       alloc_valid_i,
  input  logic [ROB_W-1:0]           alloc_tag_i,
  input  logic                       alloc_rd_used_i,
  input  logic [PREG_W-1:0]          alloc_old_prd_i,
  output logic                       ready_o,
  input  logic [WB_PORTS-1:0]        wb_valid_i,
  input  logic [WB_PORTS*ROB_W-1:0]  wb_tag_i,
  output logic [COMMIT_W-1:0]        commit_o,
  output logic [CNT_W-1:0]           commit_cnt_o,
  output logic [COMMIT_W-1:0]        free_req_o,
  output logic [COMMIT_W*PREG_W-1:0] free_preg_o,
  output logic [DEPTH-1:0]           live_tag_o,
  output logic [ROB_W:0]             count_o
`ifdef ROB_STATS_EN
  ,
  output logic [31:0]                stat_retired_o,
  output logic [31:0]                stat_recover_o,
  output logic [31:0]                stat_full_o,
  output logic [31:0]                stat_bad_recover_o
`endif
);
  localparam logic [ROB_W:0] FULL = (ROB_W+1)'(DEPTH);

  logic [DEPTH-1:0]             r_valid, r_done, r_rd_used;
  logic [DEPTH-1:0][ROB_W-1:0]  r_tag, r_map;
  logic [DEPTH-1:0][PREG_W-1:0] r_old_prd;
  logic [ROB_W-1:0]             r_head, r_tail;
  logic [ROB_W:0]               r_count;

  logic [DEPTH-1:0]               w_live, w_wb_hit;
  logic [DEPTH-1:0][ROB_W-1:0]    w_off;
  logic [COMMIT_W-1:0][ROB_W-1:0] w_cidx;
  logic [COMMIT_W-1:0]            w_commit;
  logic [CNT_W-1:0]               w_n;
  logic                           w_run, w_rec, w_alloc;
  logic [ROB_W-1:0]               w_rslot;
  logic [ROB_W:0]                 w_keep;

  assign ready_o      = (r_count < FULL);
  assign count_o      = r_count;
  assign live_tag_o   = w_live;
  assign commit_o     = w_commit;
  assign commit_cnt_o = w_n;

  always_comb begin
    w_live = '0;
    for (int i = 0; i < DEPTH; i++)
      if (r_valid[i]) w_live[r_tag[i]] = 1'b1;
  end

  always_comb begin
    w_wb_hit = '0;
    for (int i = 0; i < DEPTH; i++)
      for (int p = 0; p < WB_PORTS; p++)
        if (wb_valid_i[p] && (wb_tag_i[p*ROB_W +: ROB_W] == r_tag[i])) w_wb_hit[i] = 1'b1;
  end

  // keep is one wider than a slot index so a full ROB recovering to its youngest entry keeps DEPTH
  assign w_rslot = r_map[recover_tag_i];
  assign w_keep  = {1'b0, ROB_W'(w_rslot - r_head)} + (ROB_W+1)'(1);
  assign w_rec   = recover_i && w_live[recover_tag_i] && !flush_i && !rst;
  assign w_alloc = alloc_valid_i && ready_o && !recover_i && !flush_i && !rst;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_off
      assign w_off[gi] = ROB_W'(gi) - r_head;
    end
    for (gi = 0; gi < COMMIT_W; gi++) begin : g_lane
      assign w_cidx[gi] = r_head + ROB_W'(gi);
      rob_mc_lane #(.PREG_W(PREG_W)) u_lane (
        .i_commit   (w_commit[gi]),
        .i_rd_used  (r_rd_used[w_cidx[gi]]),
        .i_old_prd  (r_old_prd[w_cidx[gi]]),
        .o_free_req (free_req_o[gi]),
        .o_free_preg(free_preg_o[gi*PREG_W +: PREG_W])
      );
    end
  endgenerate

  // Retire the contiguous done prefix from head; a recovery also caps it at the kept region.
  always_comb begin
    w_n      = '0;
    w_commit = '0;
    w_run    = !flush_i && !rst;
    for (int k = 0; k < COMMIT_W; k++) begin
      if (w_run && r_valid[w_cidx[k]] && r_done[w_cidx[k]] &&
          ((ROB_W+1)'(k) < r_count) && (!w_rec || ((ROB_W+1)'(k) < w_keep))) begin
        w_commit[k] = 1'b1;
        w_n         = w_n + CNT_W'(1);
      end else begin
        w_run = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      r_valid   <= '0;
      r_done    <= '0;
      r_rd_used <= '0;
      r_tag     <= '0;
      r_old_prd <= '0;
      r_map     <= '0;
      r_head    <= '0;
      r_tail    <= '0;
      r_count   <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        if (r_valid[i] && w_wb_hit[i]) r_done[i] <= 1'b1;
      for (int k = 0; k < COMMIT_W; k++)
        if (w_commit[k]) begin
          r_valid[w_cidx[k]] <= 1'b0;
          r_done[w_cidx[k]]  <= 1'b0;
        end
      r_head <= r_head + ROB_W'(w_n);
      if (w_rec) begin
        for (int i = 0; i < DEPTH; i++)
          if ({1'b0, w_off[i]} >= w_keep) begin
            r_valid[i] <= 1'b0;
            r_done[i]  <= 1'b0;
          end
        r_tail  <= w_rslot + ROB_W'(1);
        r_count <= w_keep - (ROB_W+1)'(w_n);
      end else begin
        if (w_alloc) begin
          r_valid[r_tail]    <= 1'b1;
          r_done[r_tail]     <= 1'b0;
          r_tag[r_tail]      <= alloc_tag_i;
          r_rd_used[r_tail]  <= alloc_rd_used_i;
          r_old_prd[r_tail]  <= alloc_old_prd_i;
          r_map[alloc_tag_i] <= r_tail;
          r_tail             <= r_tail + ROB_W'(1);
        end
        r_count <= r_count + (ROB_W+1)'(w_alloc) - (ROB_W+1)'(w_n);
      end
    end
  end

`ifdef ROB_STATS_EN
  logic [31:0] r_st_ret, r_st_rec, r_st_full, r_st_bad;

  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[32] ? '1 : s[31:0];
  endfunction

  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      r_st_ret  <= '0;
      r_st_rec  <= '0;
      r_st_full <= '0;
      r_st_bad  <= '0;
    end else begin
      r_st_ret  <= sat_add(r_st_ret, 32'(w_n));
      r_st_rec  <= sat_add(r_st_rec, 32'(w_rec));
      r_st_full <= sat_add(r_st_full, 32'(alloc_valid_i && !ready_o));
      r_st_bad  <= sat_add(r_st_bad, 32'(recover_i && !w_live[recover_tag_i]));
    end
  end

  assign stat_retired_o     = r_st_ret;
  assign stat_recover_o     = r_st_rec;
  assign stat_full_o        = r_st_full;
  assign stat_bad_recover_o = r_st_bad;
`endif
endmodule

// File: tb/tb_rob_mc.sv
// Bench for rob_mc (DEPTH=8, COMMIT_W=2, WB_PORTS=3): vector table, corner sequences, random phase.
module tb_rob_mc;
  localparam int DEPTH = 8, CW = 2, WBP = 3, RW = 3, PW = 7;

  logic clk = 1'b0;
  logic rst, flush_i, recover_i, alloc_valid_i, alloc_rd_used_i, ready_o;
  logic [RW-1:0]     recover_tag_i, alloc_tag_i;
  logic [PW-1:0]     alloc_old_prd_i;
  logic [WBP-1:0]    wb_valid_i;
  logic [WBP*RW-1:0] wb_tag_i;
  logic [CW-1:0]     commit_o, free_req_o;
  logic [1:0]        commit_cnt_o;
  logic [CW*PW-1:0]  free_preg_o;
  logic [DEPTH-1:0]  live_tag_o;
  logic [RW:0]       count_o;

  rob_mc #(.DEPTH(DEPTH), .COMMIT_W(CW), .WB_PORTS(WBP), .PREG_W(PW)) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i), .recover_i(recover_i),
    .recover_tag_i(recover_tag_i), .alloc_valid_i(alloc_valid_i), .alloc_tag_i(alloc_tag_i),
    .alloc_rd_used_i(alloc_rd_used_i), .alloc_old_prd_i(alloc_old_prd_i), .ready_o(ready_o),
    .wb_valid_i(wb_valid_i), .wb_tag_i(wb_tag_i), .commit_o(commit_o),
    .commit_cnt_o(commit_cnt_o), .free_req_o(free_req_o), .free_preg_o(free_preg_o),
    .live_tag_o(live_tag_o), .count_o(count_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit rs, fl, av; int at; bit rdu; int prd;
    bit [2:0] wbv; int w0, w1, w2; bit rec; int rt;
    bit hen; int hc, hn, hcount, hrdy, hfq, hpg;
  } vec_t;
  typedef struct { int commit, cnt, freq, preg, ready, count, live; } exp_t;
  typedef struct { int tag; bit done; bit rdu; int prd; } ment_t;

  ment_t mq[$];
  exp_t  sb[$];
  vec_t  vt[$];
  int errors = 0, checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mkn(bit rs, bit fl, bit av, int at, bit rdu, int prd,
                               bit [2:0] wbv, int w0, int w1, int w2, bit rec, int rt);
    vec_t v;
    v = '{rs:rs, fl:fl, av:av, at:at, rdu:rdu, prd:prd, wbv:wbv, w0:w0, w1:w1, w2:w2,
          rec:rec, rt:rt, hen:1'b0, hc:0, hn:0, hcount:0, hrdy:0, hfq:0, hpg:0};
    return v;
  endfunction

  function automatic vec_t mkh(bit rs, bit fl, bit av, int at, bit rdu, int prd,
                               bit [2:0] wbv, int w0, int w1, int w2,
                               int hc, int hn, int hcount, int hrdy, int hfq, int hpg);
    vec_t v;
    v = mkn(rs, fl, av, at, rdu, prd, wbv, w0, w1, w2, 1'b0, 0);
    v.hen = 1'b1; v.hc = hc; v.hn = hn; v.hcount = hcount;
    v.hrdy = hrdy; v.hfq = hfq; v.hpg = hpg;
    return v;
  endfunction

  function automatic vec_t idle();
    return mkn(0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0);
  endfunction
  function automatic vec_t rsv();
    return mkn(1, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0);
  endfunction
  function automatic vec_t al(int t, bit rdu, int prd);
    return mkn(0, 0, 1, t, rdu, prd, 3'b000, 0, 0, 0, 0, 0);
  endfunction
  function automatic vec_t wbx(bit [2:0] v, int a, int b, int c);
    return mkn(0, 0, 0, 0, 0, 0, v, a, b, c, 0, 0);
  endfunction

  // One cycle: drive, push model expectation, sample mid-cycle, compare, advance model.
  task automatic tick(input vec_t v, input string nm);
    exp_t e, g;
    int sz, n, cap, keep;
    bit rok;
    logic [7:0] live;
    int wt[3];
    @(negedge clk);
    rst = v.rs; flush_i = v.fl; alloc_valid_i = v.av; alloc_tag_i = RW'(v.at);
    alloc_rd_used_i = v.rdu; alloc_old_prd_i = PW'(v.prd);
    wb_valid_i = v.wbv; wb_tag_i = {RW'(v.w2), RW'(v.w1), RW'(v.w0)};
    recover_i = v.rec; recover_tag_i = RW'(v.rt);
    wt[0] = v.w0; wt[1] = v.w1; wt[2] = v.w2;
    sz = mq.size(); live = '0; keep = 0;
    for (int j = 0; j < sz; j++) begin
      live[mq[j].tag] = 1'b1;
      if (mq[j].tag == v.rt) keep = j + 1;
    end
    rok = v.rec && live[v.rt] && !v.rs && !v.fl;
    cap = (sz < CW) ? sz : CW;
    if (rok && keep < cap) cap = keep;
    n = 0;
    while (n < cap && mq[n].done) n++;
    if (v.rs || v.fl) n = 0;
    e.commit = (1 << n) - 1; e.cnt = n; e.freq = 0; e.preg = 0;
    for (int k = 0; k < n; k++)
      if (mq[k].rdu && mq[k].prd != 0) begin
        e.freq |= (1 << k);
        e.preg |= mq[k].prd << (PW * k);
      end
    e.ready = (sz < DEPTH) ? 1 : 0; e.count = sz; e.live = int'(live);
    sb.push_back(e);
    #1;
    g = sb.pop_front();
    chk({nm, " commit"}, 32'(commit_o), g.commit);
    chk({nm, " cnt"},    32'(commit_cnt_o), g.cnt);
    chk({nm, " freq"},   32'(free_req_o), g.freq);
    chk({nm, " preg"},   32'(free_preg_o), g.preg);
    chk({nm, " ready"},  32'(ready_o), g.ready);
    chk({nm, " count"},  32'(count_o), g.count);
    chk({nm, " live"},   32'(live_tag_o), g.live);
    if (v.hen) begin
      chk({nm, " hand commit"}, 32'(commit_o), v.hc);
      chk({nm, " hand cnt"},    32'(commit_cnt_o), v.hn);
      chk({nm, " hand count"},  32'(count_o), v.hcount);
      chk({nm, " hand ready"},  32'(ready_o), v.hrdy);
      chk({nm, " hand freq"},   32'(free_req_o), v.hfq);
      chk({nm, " hand preg"},   32'(free_preg_o), v.hpg);
    end
    if (v.rs || v.fl) mq.delete();
    else begin
      for (int j = 0; j < mq.size(); j++)
        for (int p = 0; p < WBP; p++)
          if (v.wbv[p] && wt[p] == mq[j].tag) mq[j].done = 1'b1;
      repeat (n) void'(mq.pop_front());
      if (rok) begin
        while (mq.size() > keep - n) void'(mq.pop_back());
      end else if (!v.rec && v.av && sz < DEPTH)
        mq.push_back('{tag:v.at, done:1'b0, rdu:v.rdu, prd:v.prd});
    end
  endtask

  initial begin
    rst = 1'b1; flush_i = 0; recover_i = 0; recover_tag_i = 0; alloc_valid_i = 0;
    alloc_tag_i = 0; alloc_rd_used_i = 0; alloc_old_prd_i = 0; wb_valid_i = 0; wb_tag_i = 0;
    repeat (2) @(posedge clk);

    // basic fill, three-port WB, two-wide then one-wide retire
    vt.push_back(mkh(0,0,1,0,0,0, 3'b000,0,0,0, 0,0,0,1,0,0));
    vt.push_back(mkh(0,0,1,1,0,0, 3'b000,0,0,0, 0,0,1,1,0,0));
    vt.push_back(mkh(0,0,1,2,0,0, 3'b000,0,0,0, 0,0,2,1,0,0));
    vt.push_back(mkh(0,0,1,3,0,0, 3'b000,0,0,0, 0,0,3,1,0,0));
    vt.push_back(mkh(0,0,0,0,0,0, 3'b111,0,1,2, 0,0,4,1,0,0));
    vt.push_back(mkh(0,0,0,0,0,0, 3'b000,0,0,0, 3,2,4,1,0,0));
    vt.push_back(mkh(0,0,0,0,0,0, 3'b000,0,0,0, 1,1,2,1,0,0));
    vt.push_back(mkh(0,0,0,0,0,0, 3'b000,0,0,0, 0,0,1,1,0,0));
    // full ROB, dropped alloc, no alloc on same-cycle commit, wrap into slot 0
    vt.push_back(mkh(1,0,0,0,0,0, 3'b000,0,0,0, 0,0,1,1,0,0));
    for (int i = 0; i < 8; i++)
      vt.push_back(mkh(0,0,1,i,1,9+i, 3'b000,0,0,0, 0,0,i,1,0,0));
    vt.push_back(mkh(0,0,1,0,1,9, 3'b000,0,0,0, 0,0,8,0,0,0));
    vt.push_back(mkh(0,0,0,0,0,0, 3'b011,0,1,0, 0,0,8,0,0,0));
    vt.push_back(mkh(0,0,1,0,0,0, 3'b000,0,0,0, 3,2,8,0,3,1289));
    vt.push_back(mkh(0,0,1,0,0,0, 3'b000,0,0,0, 0,0,6,1,0,0));
    vt.push_back(mkh(0,0,0,0,0,0, 3'b000,0,0,0, 0,0,7,1,0,0));
    // free-list lanes: old_prd 0 is not freed
    vt.push_back(mkh(1,0,0,0,0,0, 3'b000,0,0,0, 0,0,7,1,0,0));
    vt.push_back(mkh(0,0,1,5,1,0, 3'b000,0,0,0, 0,0,0,1,0,0));
    vt.push_back(mkh(0,0,1,6,1,12, 3'b000,0,0,0, 0,0,1,1,0,0));
    vt.push_back(mkh(0,0,0,0,0,0, 3'b011,5,6,0, 0,0,2,1,0,0));
    vt.push_back(mkh(0,0,0,0,0,0, 3'b000,0,0,0, 3,2,2,1,2,1536));
    vt.push_back(mkh(0,0,0,0,0,0, 3'b000,0,0,0, 0,0,0,1,0,0));
    foreach (vt[i]) tick(vt[i], $sformatf("vec%0d", i));

    // recovery across the wrap with head at slot 6
    tick(rsv(), "t4 rst");
    for (int t = 0; t < 6; t++) tick(al(t, 0, 0), "t4 fill");
    tick(wbx(3'b111, 0, 1, 2), "t4 wb");
    tick(wbx(3'b111, 3, 4, 5), "t4 wb");
    repeat (3) tick(idle(), "t4 drain");
    for (int t = 2; t < 7; t++) tick(al(t, 1, 18 + t), "t4 alloc");
    tick(wbx(3'b001, 2, 0, 0), "t4 wb2");
    tick(mkn(0,0,0,0,0,0, 3'b000,0,0,0, 1,3), "t4 recover");
    chk("t4 recover commit", 32'(commit_o), 1);
    chk("t4 recover count", 32'(count_o), 5);
    tick(idle(), "t4 after");
    chk("t4 after count", 32'(count_o), 1);
    chk("t4 after live", 32'(live_tag_o), 32'h08);
    tick(al(7, 1, 30), "t4 realloc");
    tick(wbx(3'b011, 3, 7, 0), "t4 wb3");
    tick(idle(), "t4 commit");
    chk("t4 commit2", 32'(commit_o), 3);
    chk("t4 freeq", 32'(free_req_o), 3);

    // full ROB recovering to the head entry, alloc suppressed
    tick(rsv(), "t5 rst");
    for (int t = 0; t < 8; t++) tick(al(t, 0, 0), "t5 fill");
    tick(mkn(0,0,1,0,0,0, 3'b000,0,0,0, 1,0), "t5 recover");
    chk("t5 recover count", 32'(count_o), 8);
    tick(idle(), "t5 after");
    chk("t5 after count", 32'(count_o), 1);
    chk("t5 after live", 32'(live_tag_o), 32'h01);
    chk("t5 after ready", 32'(ready_o), 1);
    tick(al(5, 0, 0), "t5 alloc");
    tick(idle(), "t5 check");
    chk("t5 alloc count", 32'(count_o), 2);

    // flush beats recover and a pending commit
    tick(wbx(3'b001, 0, 0, 0), "t6 wb");
    tick(mkn(0,1,1,6,0,0, 3'b000,0,0,0, 1,0), "t6 flush");
    chk("t6 flush commit", 32'(commit_o), 0);
    tick(idle(), "t6 after");
    chk("t6 after count", 32'(count_o), 0);
    chk("t6 after live", 32'(live_tag_o), 0);
    chk("t6 after ready", 32'(ready_o), 1);

    // recover on a non-live tag: no-op, alloc still suppressed
    tick(al(1, 0, 0), "bad alloc");
    tick(mkn(0,0,1,2,0,0, 3'b000,0,0,0, 1,4), "bad recover");
    tick(idle(), "bad after");
    chk("bad after count", 32'(count_o), 1);
    chk("bad after live", 32'(live_tag_o), 32'h02);

    // random traffic against the queue model
    for (int c = 0; c < 400; c++) begin
      vec_t v;
      int fr[$];
      logic [7:0] lv;
      lv = '0;
      fr.delete();
      foreach (mq[j]) lv[mq[j].tag] = 1'b1;
      for (int t = 0; t < 8; t++) if (!lv[t]) fr.push_back(t);
      v = mkn(0, ($urandom % 60) == 0, ($urandom % 3) != 0,
              (fr.size() > 0) ? fr[$urandom % fr.size()] : 0,
              $urandom % 2, (($urandom % 4) == 0) ? 0 : int'($urandom % 128),
              3'($urandom % 8), int'($urandom % 8), int'($urandom % 8), int'($urandom % 8),
              ($urandom % 12) == 0, int'($urandom % 8));
      tick(v, "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
